// File: rtl/slider_pkg.sv
// Shared constants and FSM state type for the slider scanner and its SPI engine.
package slider_pkg;
  localparam int ADC_BITS   = 12;
  localparam int FRAME_BITS = 16;
  localparam int MAX_CH     = 8;
  localparam int ADDR_LSB   = 11;
  localparam int ADDR_W     = $clog2(MAX_CH);

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    GAP
  } state_e;
endpackage

// File: rtl/slider_spi_xfer.sv
// One 16-bit SPI mode-3 transfer: SS_n low, half-period lead, 16 SCLK periods,
// ending on the 16th rising edge; done pulses in the cycle that edge samples MISO.
module slider_spi_xfer
  import slider_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [FRAME_BITS-1:0] tx_i,
  input  logic                  miso_i,
  output logic                  ss_n_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  output logic                  done_o,
  output logic [FRAME_BITS-1:0] rx_o
);
  localparam int HALF   = SCLK_DIV / 2;
  localparam int CW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int HW     = $clog2(2 * FRAME_BITS);
  localparam int LAST_H = 2 * FRAME_BITS - 1;

  logic                  busy_q, busy_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [HW-1:0]         half_q, half_d;
  logic                  ss_n_q, ss_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-2:0] rx_q, rx_d;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    half_d = half_q;
    ss_n_d = ss_n_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    done_o = 1'b0;
    if (!busy_q) begin
      if (start_i) begin
        busy_d = 1'b1;
        ss_n_d = 1'b0;
        cnt_d  = '0;
        half_d = '0;
        tx_d   = tx_i;
      end
    end else if (cnt_q == CW'(HALF - 1)) begin
      cnt_d  = '0;
      half_d = half_q + 1'b1;
      // Even halves are SCLK-high (lead or high phase): their end is a falling edge.
      if (!half_q[0]) begin
        sclk_d = 1'b0;
        mosi_d = tx_q[FRAME_BITS-1];
        tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
      end else begin
        sclk_d = 1'b1;
        rx_d   = {rx_q[FRAME_BITS-3:0], miso_i};
        if (half_q == HW'(LAST_H)) begin
          busy_d = 1'b0;
          ss_n_d = 1'b1;
          done_o = 1'b1;
        end
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      half_q <= '0;
      ss_n_q <= 1'b1;
      sclk_q <= 1'b1;
      mosi_q <= 1'b0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      half_q <= half_d;
      ss_n_q <= ss_n_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end

  assign rx_o   = {rx_q, miso_i};
  assign ss_n_o = ss_n_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
endmodule

// File: rtl/slider_scanner.sv
// Round-robin ADC128S-style channel scanner with prime frame and per-channel results.
// Optional IIR smoothing of each channel is built when SLIDER_FILTER_EN is defined.
module slider_scanner
  import slider_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int SCLK_DIV   = 32,
  parameter int FILT_SHIFT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  output logic [NUM_CH*ADC_BITS-1:0]   pot,
  output logic                         valid,
  output logic [2:0]                   ch,
  output logic                         SS_n,
  output logic                         SCLK,
  output logic                         MOSI,
  input  logic                         MISO
);
  localparam int GW = $clog2(SCLK_DIV);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     prev_q, prev_d;
  logic                  prime_q, prime_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                  valid_q, valid_d;
  logic [2:0]            ch_q, ch_d;
  logic                  start, done, upd, reload;
  logic [FRAME_BITS-1:0] tx_word, rx_word;
  logic [ADC_BITS-1:0]   sample;
  logic [3:0]            unused_rx;
  logic [ADDR_W-1:0]     addr_next;

  assign tx_word   = FRAME_BITS'(addr_q) << ADDR_LSB;
  assign sample    = rx_word[ADC_BITS-1:0];
  assign unused_rx = rx_word[FRAME_BITS-1:ADC_BITS];
  assign addr_next = (addr_q == ADDR_W'(NUM_CH - 1)) ? '0 : addr_q + 1'b1;

  slider_spi_xfer #(.SCLK_DIV(SCLK_DIV)) u_xfer (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .tx_i   (tx_word),
    .miso_i (MISO),
    .ss_n_o (SS_n),
    .sclk_o (SCLK),
    .mosi_o (MOSI),
    .done_o (done),
    .rx_o   (rx_word)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    prev_d    = prev_q;
    prime_d   = prime_q;
    gap_cnt_d = gap_cnt_q;
    ch_d      = ch_q;
    valid_d   = 1'b0;
    start     = 1'b0;
    upd       = 1'b0;
    reload    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          start   = 1'b1;
          reload  = 1'b1;
          state_d = FRAME;
        end
      end
      FRAME: begin
        if (done) begin
          // The returned sample belongs to the address sent in the previous frame.
          upd       = !prime_q;
          valid_d   = !prime_q;
          ch_d      = prime_q ? ch_q : 3'(prev_q);
          prev_d    = addr_q;
          addr_d    = addr_next;
          prime_d   = 1'b0;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(SCLK_DIV - 1)) begin
          if (en) begin
            start   = 1'b1;
            state_d = FRAME;
          end else begin
            addr_d  = '0;
            prime_d = 1'b1;
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      prev_q    <= '0;
      prime_q   <= 1'b1;
      gap_cnt_q <= '0;
      valid_q   <= 1'b0;
      ch_q      <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      prev_q    <= prev_d;
      prime_q   <= prime_d;
      gap_cnt_q <= gap_cnt_d;
      valid_q   <= valid_d;
      ch_q      <= ch_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [ADC_BITS-1:0] pot_q;
    logic                hit;
    assign hit = upd && (prev_q == ADDR_W'(gi));
`ifdef SLIDER_FILTER_EN
    logic                       first_q;
    logic signed [ADC_BITS:0]   diff, step;
    logic        [ADC_BITS-1:0] filt;
    assign diff = $signed({1'b0, sample}) - $signed({1'b0, pot_q});
    assign step = diff >>> FILT_SHIFT;
    // Result always lies between old value and sample, so modulo-4096 add is exact.
    assign filt = pot_q + step[ADC_BITS-1:0];
    always_ff @(posedge clk) begin
      if (rst) begin
        pot_q   <= '0;
        first_q <= 1'b1;
      end else begin
        if (reload) first_q <= 1'b1;
        if (hit) begin
          pot_q   <= first_q ? sample : filt;
          first_q <= 1'b0;
        end
      end
    end
`else
    always_ff @(posedge clk) begin
      if (rst) pot_q <= '0;
      else if (hit) pot_q <= sample;
    end
`endif
    assign pot[ADC_BITS*gi +: ADC_BITS] = pot_q;
  end

`ifndef SLIDER_FILTER_EN
  localparam int unused_filt_shift = FILT_SHIFT;
  logic unused_reload;
  assign unused_reload = reload;
`endif

  assign valid = valid_q;
  assign ch    = ch_q;
endmodule
